tlut_psum_collector: RTL and testbench

//  Downstream stage of the TLUT SIMD cell. Captures the DIM_A-lane product vector at the end of each rollover window.

---
 rtl/tlut_pkg.sv | 38 +++
 rtl/tlut_psum_lane.sv | 47 ++++
 rtl/tlut_psum_collector.sv | 128 ++++++++++++
 tb/tb_tlut_psum_collector.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlut_pkg.sv
// rtl/tlut_pkg.sv - shared types, defaults and lane adder for the TLUT partial-sum collector
//
// Purpose : FSM state encoding, parameter defaults and the per-lane add used by
//           tlut_psum_lane.
// Macro   : TLUT_PSUM_SAT_EN - when defined, lane_add saturates at 2^w-1;
//           when undefined it wraps modulo 2^w.
// Ports   : none (package).
package tlut_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } psum_state_e;

    localparam int DIM_A_DEF      = 8;
    localparam int ACC_WIDTH_DEF  = 16;
    localparam int PSUM_WIDTH_DEF = 24;
    localparam int TILE_W_DEF     = 8;

    // Operands are zero-extended to 64 bits by the caller; w is the real lane
    // width. One extra bit of headroom lets the saturating build see the carry.
    function automatic logic [63:0] lane_add(input logic [63:0] a,
                                             input logic [63:0] b,
                                             input int unsigned w);
        logic [64:0] lim;
        logic [64:0] sum;
        lim = (65'd1 << w) - 65'd1;
        sum = {1'b0, a} + {1'b0, b};
`ifdef TLUT_PSUM_SAT_EN
        if (sum > lim) begin
            sum = lim;
        end
`endif
        return 64'(sum & lim);
    endfunction

endpackage

// File: rtl/tlut_psum_lane.sv
// rtl/tlut_psum_lane.sv - one partial-sum accumulator lane
//
// Purpose : PSUM_WIDTH register that is cleared on job start and accumulates
//           one zero-extended product per add pulse (wrap or saturate, see
//           TLUT_PSUM_SAT_EN in tlut_pkg).
// Ports   : clk_i, rst_ni  clock / async active-low reset
//           clr_i          clear the lane (takes priority over add_i)
//           add_i          accumulate prod_i this cycle
//           prod_i         ACC_WIDTH product lane
//           psum_o         current partial sum
module tlut_psum_lane
    import tlut_pkg::*;
#(
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int PSUM_WIDTH = PSUM_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  add_i,
    input  logic [ACC_WIDTH-1:0]  prod_i,
    output logic [PSUM_WIDTH-1:0] psum_o
);

    logic [PSUM_WIDTH-1:0] psum_q;
    logic [PSUM_WIDTH-1:0] psum_d;

    always_comb begin
        psum_d = psum_q;
        if (clr_i) begin
            psum_d = '0;
        end else if (add_i) begin
            psum_d = PSUM_WIDTH'(lane_add(64'(psum_q), 64'(prod_i), PSUM_WIDTH));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            psum_q <= '0;
        end else begin
            psum_q <= psum_d;
        end
    end

    assign psum_o = psum_q;

endmodule

// File: rtl/tlut_psum_collector.sv
// rtl/tlut_psum_collector.sv - accumulates DIM_A-lane product vectors over K tiles and drains them
//
// Purpose : IDLE -> ACCUM (NUM_TILES window_done pulses summed per lane)
//           -> DRAIN (one lane per valid/ready beat) -> IDLE with a done pulse.
// Macro   : TLUT_PSUM_SAT_EN selects saturating lane adds (port list unchanged).
// Ports   : clk_i, rst_ni          clock / async active-low reset
//           start_i, num_tiles_i   job start (IDLE only) and tile count (0 means 1)
//           window_done_i, prod_in_i  window pulse and DIM_A*ACC_WIDTH product vector
//           out_valid_o, out_ready_i, out_data_o, out_idx_o, out_last_o  drain stream
//           busy_o                 high in ACCUM or DRAIN
//           done_o                 1-cycle pulse after last beat accepted
//           ovf_err_o              sticky: window_done outside ACCUM
module tlut_psum_collector
    import tlut_pkg::*;
#(
    parameter int  DIM_A      = DIM_A_DEF,
    parameter int  ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int  PSUM_WIDTH = PSUM_WIDTH_DEF,
    parameter int  TILE_W     = TILE_W_DEF,
    localparam int IDX_W      = (DIM_A > 1) ? $clog2(DIM_A) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic [TILE_W-1:0]          num_tiles_i,
    input  logic                       window_done_i,
    input  logic [DIM_A*ACC_WIDTH-1:0] prod_in_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [PSUM_WIDTH-1:0]      out_data_o,
    output logic [IDX_W-1:0]           out_idx_o,
    output logic                       out_last_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       ovf_err_o
);

    psum_state_e       state_q;
    logic [TILE_W-1:0] tile_cnt_q;
    logic [TILE_W-1:0] ntiles_q;
    logic [IDX_W-1:0]  idx_q;
    logic              out_valid_q;
    logic              done_q;
    logic              ovf_q;

    logic              lane_clr;
    logic              lane_add_en;
    logic              idx_is_last;
    logic [PSUM_WIDTH-1:0] psum [DIM_A];

    assign lane_clr    = (state_q == ST_IDLE) && start_i;
    assign lane_add_en = (state_q == ST_ACCUM) && window_done_i;
    assign idx_is_last = (idx_q == IDX_W'(DIM_A - 1));

    for (genvar i = 0; i < DIM_A; i++) begin : g_lane
        tlut_psum_lane #(
            .ACC_WIDTH (ACC_WIDTH),
            .PSUM_WIDTH(PSUM_WIDTH)
        ) u_lane (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .clr_i (lane_clr),
            .add_i (lane_add_en),
            .prod_i(prod_in_i[i*ACC_WIDTH +: ACC_WIDTH]),
            .psum_o(psum[i])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            tile_cnt_q  <= '0;
            ntiles_q    <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        tile_cnt_q <= '0;
                        idx_q      <= '0;
                        ovf_q      <= 1'b0;
                        ntiles_q   <= (num_tiles_i == '0) ? TILE_W'(1) : num_tiles_i;
                        state_q    <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (window_done_i) begin
                        tile_cnt_q <= tile_cnt_q + TILE_W'(1);
                        if (tile_cnt_q == ntiles_q - TILE_W'(1)) begin
                            state_q     <= ST_DRAIN;
                            idx_q       <= '0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_ready_i) begin
                        if (idx_is_last) begin
                            state_q     <= ST_IDLE;
                            out_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            // A stray window result is an error even if a start lands in the same cycle.
            if (window_done_i && (state_q != ST_ACCUM)) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_valid_q ? psum[idx_q] : '0;
    assign out_idx_o   = out_valid_q ? idx_q : '0;
    assign out_last_o  = out_valid_q && idx_is_last;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = done_q;
    assign ovf_err_o   = ovf_q;

endmodule

// File: tb/tb_tlut_psum_collector.sv
// tb/tb_tlut_psum_collector.sv - self-checking bench for tlut_psum_collector
module tb_tlut_psum_collector;

    localparam int DIM_A  = 8;
    localparam int ACC_W  = 16;
    localparam int PSUM_W = 16;
    localparam int TILE_W = 8;
    localparam int IDX_W  = 3;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   start;
    logic [TILE_W-1:0]      num_tiles;
    logic                   window_done;
    logic [DIM_A*ACC_W-1:0] prod_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [PSUM_W-1:0]      out_data;
    logic [IDX_W-1:0]       out_idx;
    logic                   out_last;
    logic                   busy;
    logic                   done;
    logic                   ovf_err;

    always #5 clk = ~clk;

    tlut_psum_collector #(
        .DIM_A     (DIM_A),
        .ACC_WIDTH (ACC_W),
        .PSUM_WIDTH(PSUM_W),
        .TILE_W    (TILE_W)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .num_tiles_i  (num_tiles),
        .window_done_i(window_done),
        .prod_in_i    (prod_in),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .out_idx_o    (out_idx),
        .out_last_o   (out_last),
        .busy_o       (busy),
        .done_o       (done),
        .ovf_err_o    (ovf_err)
    );

    typedef struct {
        logic [PSUM_W-1:0] data;
        logic [IDX_W-1:0]  idx;
        logic              last;
    } beat_t;

    typedef struct {
        int                num_tiles;
        int                base;
        int                step;
        int                ready_mode;
        logic [PSUM_W-1:0] exp_lane7;
    } vec_t;

    beat_t             sb[$];
    int                n_tests = 0;
    int                n_fail  = 0;
    logic              done_due = 1'b0;
    logic [PSUM_W-1:0] last_seen = '0;
    int                beats_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: the head beat must be presented on every valid cycle,
    // so stalls are checked against the same expectation until it is accepted.
    task automatic monitor_loop();
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                done_due = 1'b0;
            end else begin
                check("done_pulse", done, done_due);
                done_due = 1'b0;
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_beat", out_valid, 0);
                    end else begin
                        e = sb[0];
                        check("out_data", out_data, e.data);
                        check("out_idx", out_idx, e.idx);
                        check("out_last", out_last, e.last);
                        if (out_ready) begin
                            void'(sb.pop_front());
                            beats_seen++;
                            if (e.last) begin
                                done_due  = 1'b1;
                                last_seen = out_data;
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic start_job(input int nt);
        start     = 1'b1;
        num_tiles = TILE_W'(nt);
        tick();
        start     = 1'b0;
    endtask

    task automatic send_window(input int base, input int step);
        for (int i = 0; i < DIM_A; i++) begin
            prod_in[i*ACC_W +: ACC_W] = ACC_W'(base + step * i);
        end
        window_done = 1'b1;
        tick();
        window_done = 1'b0;
    endtask

    task automatic push_expect(input int eff, input int base, input int step);
        longint s;
        beat_t  b;
        for (int i = 0; i < DIM_A; i++) begin
            s = longint'(eff) * longint'((base + step * i) % 65536);
`ifdef TLUT_PSUM_SAT_EN
            if (s > 65535) s = 65535;
`else
            s = s % 65536;
`endif
            b.data = PSUM_W'(s);
            b.idx  = IDX_W'(i);
            b.last = (i == DIM_A - 1);
            sb.push_back(b);
        end
    endtask

    task automatic drain(input int rmode, input int budget);
        for (int k = 0; k < budget && sb.size() != 0; k++) begin
            out_ready = (rmode == 0) || (k % 3 == 0);
            tick();
        end
        check("drain_timeout", sb.size(), 0);
        out_ready = 1'b0;
        tick();
        tick();
        check("busy_after_drain", busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_idx"}, out_idx, 0);
        check({tag, "_last"}, out_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ovf"}, ovf_err, 0);
    endtask

    vec_t vecs[4];

    initial begin
        int eff;
        int b0;
        vecs[0] = '{num_tiles: 1, base: 5,   step: 0,  ready_mode: 0, exp_lane7: 16'd5};
        vecs[1] = '{num_tiles: 3, base: 1,   step: 1,  ready_mode: 0, exp_lane7: 16'd24};
        vecs[2] = '{num_tiles: 2, base: 100, step: 10, ready_mode: 1, exp_lane7: 16'd340};
        vecs[3] = '{num_tiles: 0, base: 7,   step: 3,  ready_mode: 0, exp_lane7: 16'd28};

        rst_n = 1'b0; start = 1'b0; num_tiles = '0; window_done = 1'b0;
        prod_in = '0; out_ready = 1'b0;
        fork
            monitor_loop();
        join_none
        tick(); tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Table-driven jobs
        foreach (vecs[v]) begin
            eff = (vecs[v].num_tiles == 0) ? 1 : vecs[v].num_tiles;
            b0  = beats_seen;
            start_job(vecs[v].num_tiles);
            check("busy_in_accum", busy, 1);
            push_expect(eff, vecs[v].base, vecs[v].step);
            for (int w = 0; w < eff; w++) begin
                check("early_valid", out_valid, 0);
                send_window(vecs[v].base, vecs[v].step);
                if (w != eff - 1) tick();
            end
            drain(vecs[v].ready_mode, 200);
            check("lane7_value", last_seen, vecs[v].exp_lane7);
            check("beat_count", beats_seen - b0, DIM_A);
        end

        // window_done in IDLE and during DRAIN
        check("ovf_idle_before", ovf_err, 0);
        send_window(9, 9);
        check("ovf_after_idle_window", ovf_err, 1);
        start_job(1);
        check("ovf_cleared_by_start", ovf_err, 0);
        push_expect(1, 2, 1);
        send_window(2, 1);
        send_window(50, 50);
        check("ovf_after_drain_window", ovf_err, 1);
        drain(1, 200);
        check("ovf_still_set", ovf_err, 1);

        // Full-scale lanes over 255 tiles; a stray start mid-ACCUM is ignored
        start_job(255);
        check("ovf_cleared_255", ovf_err, 0);
        push_expect(255, 16'hFFFF, 0);
        for (int w = 0; w < 255; w++) begin
            if (w == 10) begin
                start = 1'b1; num_tiles = 8'd1;
                tick();
                start = 1'b0;
            end
            send_window(16'hFFFF, 0);
        end
        drain(0, 200);
`ifdef TLUT_PSUM_SAT_EN
        check("lane7_255", last_seen, 16'hFFFF);
`else
        check("lane7_255", last_seen, 16'hFF01);
`endif

        // Reset mid-ACCUM
        start_job(4);
        send_window(3, 3);
        send_window(3, 3);
        rst_n = 1'b0;
        tick();
        check_all_zero("rst_accum");
        rst_n = 1'b1;
        tick();

        // Reset mid-DRAIN with a stalled consumer and ovf set
        start_job(2);
        push_expect(2, 4, 4);
        send_window(4, 4);
        send_window(4, 4);
        check("valid_before_rst", out_valid, 1);
        send_window(1, 1);
        tick();
        rst_n = 1'b0;
        sb.delete();
        tick();
        check_all_zero("rst_drain");
        rst_n = 1'b1;
        tick(); tick();
        check("no_done_after_rst", done, 0);

        // Restart with num_tiles=0 behaves as one tile
        b0 = beats_seen;
        start_job(0);
        push_expect(1, 3, 2);
        send_window(3, 2);
        drain(0, 200);
        check("restart_lane7", last_seen, 16'd17);
        check("restart_beats", beats_seen - b0, DIM_A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
